// File: rtl/prog3_pkg.sv
// rtl/prog3_pkg.sv - shared state encoding and default layout constants for the program-3 multiply sequencer
package prog3_pkg;
   typedef enum logic [2:0] {IDLE, LDA, LDB, MUL, ST, DONE} state_t;

   localparam int NPAIRS   = 16;
   localparam int IN_BASE  = 0;
   localparam int OUT_BASE = 64;

   // Byte k of a 32-bit result, MSB first.
   function automatic logic [7:0] res_byte(input logic [31:0] r, input logic [1:0] k);
      return 8'(r >> (5'd24 - {k, 3'b000}));
   endfunction
endpackage

// File: rtl/booth_step16.sv
// rtl/booth_step16.sv - one radix-2 Booth step on a 33-bit partial-product register
module booth_step16 (
   input  logic [32:0] p_in,
   input  logic [15:0] a,
   output logic [32:0] p_out
);
   logic [16:0] acc;
   logic [16:0] addend;
   logic [16:0] sum;

   // 17-bit accumulate so that subtracting -32768 cannot overflow.
   always_comb begin
      acc    = {p_in[32], p_in[32:17]};
      addend = '0;
      case (p_in[1:0])
         2'b01:   addend = {a[15], a};
         2'b10:   addend = -{a[15], a};
         default: addend = '0;
      endcase
      sum   = acc + addend;
      p_out = {sum, p_in[16:1]};
   end
endmodule

// File: rtl/prog3_mul_sequencer.sv
// rtl/prog3_mul_sequencer.sv - sequencer that multiplies signed 16-bit operand pairs from byte memory and writes 32-bit products back
module prog3_mul_sequencer #(
   parameter int NPAIRS   = prog3_pkg::NPAIRS,
   parameter int IN_BASE  = prog3_pkg::IN_BASE,
   parameter int OUT_BASE = prog3_pkg::OUT_BASE,
   parameter int AW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rdata,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   output logic          busy,
   output logic          done
);
   import prog3_pkg::*;

   localparam int JW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

   state_t        state, state_nx;
   logic [JW-1:0] pair;
   logic [1:0]    cnt;
   logic [3:0]    step;
   logic [15:0]   a, b, b_in;
   logic [32:0]   p, p_nx;
   logic          last_pair;

   booth_step16 u_booth (.p_in(p), .a(a), .p_out(p_nx));

   assign last_pair = (pair == JW'(NPAIRS - 1));
   assign b_in      = (cnt == 2'd0) ? {mem_rdata, b[7:0]} : {b[15:8], mem_rdata};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LDA;
         LDA:     if (cnt == 2'd1) state_nx = LDB;
         LDB:     if (cnt == 2'd1) state_nx = MUL;
         MUL:     if (step == 4'd15) state_nx = ST;
         ST:      if (cnt == 2'd3) state_nx = last_pair ? DONE : LDA;
         DONE:    if (!start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pair <= '0; cnt <= '0; step <= '0;
         a <= '0; b <= '0; p <= '0;
         mem_addr <= '0; mem_wdata <= '0; mem_we <= 1'b0;
         busy <= 1'b0; done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               busy     <= 1'b1;
               pair     <= '0;
               cnt      <= '0;
               mem_addr <= AW'(IN_BASE);
            end
            LDA: begin
               if (cnt == 2'd0) a[15:8] <= mem_rdata;
               else             a[7:0]  <= mem_rdata;
               cnt      <= (cnt == 2'd0) ? 2'd1 : 2'd0;
               mem_addr <= mem_addr + 1'b1;
            end
            LDB: begin
               b        <= b_in;
               cnt      <= (cnt == 2'd0) ? 2'd1 : 2'd0;
               mem_addr <= mem_addr + 1'b1;
               if (cnt == 2'd1) begin
                  p    <= {16'b0, b_in, 1'b0};
                  step <= '0;
               end
            end
            MUL: begin
               p    <= p_nx;
               step <= step + 1'b1;
               // Present byte 0 of the finished product together with the first write address.
               if (step == 4'd15) begin
                  mem_addr  <= AW'(OUT_BASE) + AW'({pair, 2'b00});
                  mem_wdata <= p_nx[32:25];
                  mem_we    <= 1'b1;
                  cnt       <= '0;
               end
            end
            ST: begin
               if (cnt == 2'd3) begin
                  mem_we    <= 1'b0;
                  mem_wdata <= '0;
                  cnt       <= '0;
                  if (last_pair) begin
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     mem_addr <= '0;
                  end else begin
                     pair     <= JW'(pair + 1'b1);
                     mem_addr <= AW'(IN_BASE) + AW'({JW'(pair + 1'b1), 2'b00});
                  end
               end else begin
                  cnt       <= cnt + 1'b1;
                  mem_addr  <= mem_addr + 1'b1;
                  mem_wdata <= res_byte(p[32:1], cnt + 1'b1);
               end
            end
            DONE: if (!start) done <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/prog3_mul_sequencer.md
# prog3_mul_sequencer

Hardware sequencer for the program-3 workload: computes all products of 16 pairs of signed 16-bit operands held in data memory and writes the 32-bit signed results back to memory.
- Sits beside the core on the byte-wide data-memory port, muxed in by `top_level`.
- Reads operands from bytes 0–63 and writes products to bytes 64–127.
- Uses the same start/done handshake as the program-3 run.

## Interface
Parameters
- `NPAIRS`, default 16: number of operand pairs.
- `IN_BASE`, default 0: byte address of the first operand.
- `OUT_BASE`, default 64: byte address of the first product.
- `AW`, default 8: memory address width.

Ports
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: **asynchronous, active-low** reset.
- `start`, input, 1: run request, level-sampled.
- `mem_addr`, output, AW: byte address for read and write.
- `mem_rdata`, input, 8: read data, combinational from `mem_addr` in the same cycle.
- `mem_wdata`, output, 8: write byte.
- `mem_we`, output, 1: write enable; memory writes on the `clk` edge.
- `busy`, output, 1: high from the launch until DONE.
- `done`, output, 1: run complete; held high.

## Operation
Data layout
- Pair j operand A = {mem[IN_BASE+4j], mem[IN_BASE+4j+1]}, big-endian.
- Pair j operand B = {mem[IN_BASE+4j+2], mem[IN_BASE+4j+3]}.
- Product B*A is written as 4 bytes, MSB first, to OUT_BASE+4j … OUT_BASE+4j+3.

State machine
- **IDLE**
  - start=1 → LDA, pair counter = 0.
- **LDA** (2 cycles)
  - byte 0 latched into A[15:8], byte 1 into A[7:0].
- **LDB** (2 cycles)
  - Same for B.
  - The second cycle also initialises the Booth register P[32:0] = {16'b0, B, 1'b0}.
- **MUL** (exactly 16 cycles, radix-2 Booth)
  - On P[1:0]: 01 → P[32:17] += A; 10 → P[32:17] −= A; otherwise no add.
  - The add is done in 17 bits with sign extension, then P is shifted right arithmetically by 1.
  - Result = P[32:1], a 32-bit two's complement value.
- **ST** (4 cycles)
  - mem_we=1; byte k of the result goes to OUT_BASE+4j+k.
  - After k=3: if j==NPAIRS-1 → DONE, else j++ → LDA.
- **DONE**
  - done=1, busy=0.
  - start=0 → IDLE. start=1 is held: no relaunch until start drops.

Rules
- start while busy is ignored.
- mem_we is never asserted for addresses below OUT_BASE.
- Arithmetic is exact: full signed 16×16 → 32, no saturation. −32768 × −32768 = 0x40000000.

## Timing
Reset values (async, reset=0)
- FSM=IDLE; mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0.
- Counters and A, B, P cleared.

Per-pair and per-run timing
- Each pair takes 24 cycles: 2 LDA + 2 LDB + 16 MUL + 4 ST.
- Call the start-sampling edge in IDLE edge 0.
- Pair j's writes occur on edges 24j+21 … 24j+24.
- DONE is entered at edge 24·NPAIRS (384 at default); done/busy change right after that edge.
- busy rises right after edge 0.

Output timing
- All outputs are registered or decoded from the state register only; there is no combinational path from start to the outputs.

Reset mid-run
- Takes effect immediately.
- Products already written remain; later products are not written.
- The next start reruns from pair 0.

## Structure
- Package `prog3_pkg`: state enum {IDLE, LDA, LDB, MUL, ST, DONE}, and default constants NPAIRS, IN_BASE, OUT_BASE.
- Sub-module `booth_step16`: combinational single Booth step, P[32:0] in / A[15:0] in → next P[32:0] out.
- The sequencer holds the FSM, the pair/byte/step counters, and the A/B/P registers.

## Test plan
- **Uniform pairs**: all 16 pairs A=3, B=−5 → every product 0xFFFFFFF1; done rises after edge 384; busy low after.
- **Corners**
  - −32768 × −32768 → 0x40000000.
  - −32768 × 32767 → 0xC0008000.
  - 0 × −7 → 0.
  - 1 × −1 → 0xFFFFFFFF.
  - 32767 × 32767 → 0x3FFF0001.
- **Reset mid-run**: drop reset at cycle 100.
  - All outputs are 0 asynchronously.
  - Bytes 64–79 (pairs 0–3) hold correct products; bytes 80–127 are unchanged.
  - Restart → all 16 products correct.
- **Handshake**
  - Hold start high through DONE → no relaunch; done stays 1.
  - Drop start → IDLE with done=0.
  - Raise start → second run, identical results at edge 384.
- **Ignored start / write range**
  - Toggle start during busy → no effect on timing.
  - Monitor confirms mem_we is only asserted with mem_addr in 64–127.
  - Bytes 0–63 are never written.
- **Random**: 10 random operand files → all 160 products match A×B computed in the bench.
